cache_fill_arbiter: RTL

- Sequences the shared multi-cycle main memory (memory4c) between the I-cache, the D-cache and D-cache store write-through.
- On a cache miss it fetches the whole 16-byte block (8 x 16-bit words) with pipelined requests and streams each returned word into the missing cache.
- Single-cycle stores are serialized with fills.
- Sits between both Cache instances and memory4c inside the memory wrapper, replacing the ad hoc address/enable muxing.

---
 rtl/cache_fill_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Purpose : sequences memory4c between I-cache fills, D-cache fills and D-cache store write-through.
// Latency : store commits 1 cycle after grant; 8-word fill completes MEM_LAT+9 cycles after grant.
// Backpress: requesters hold their request until the matching done pulse; one owner at a time.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   i_miss/i_miss_addr             - I-cache miss request and missed byte address
//   d_miss/d_miss_addr             - D-cache miss request and missed byte address
//   d_wr_req/d_wr_addr/d_wr_data   - store write-through request, address, data
//   mem_data_out/mem_data_valid    - memory read return
//   mem_addr/mem_enable/mem_wr/mem_data_in - memory request port
//   fill_data/fill_idx             - word (and its block index) being written into a cache
//   i_fill_we/d_fill_we            - write strobe for the owning cache
//   i_fill_done/d_fill_done        - one-cycle block-complete pulses
//   d_wr_done                      - one-cycle store-committed pulse
//   busy                           - arbiter is not idle
module cache_fill_arbiter #(
   parameter int MEM_LAT = 4,
   parameter int WORDS   = 8,
   localparam int IW     = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_miss,
   input  logic [15:0]   i_miss_addr,
   input  logic          d_miss,
   input  logic [15:0]   d_miss_addr,
   input  logic          d_wr_req,
   input  logic [15:0]   d_wr_addr,
   input  logic [15:0]   d_wr_data,
   input  logic [15:0]   mem_data_out,
   input  logic          mem_data_valid,
   output logic [15:0]   mem_addr,
   output logic          mem_enable,
   output logic          mem_wr,
   output logic [15:0]   mem_data_in,
   output logic [15:0]   fill_data,
   output logic [IW-1:0] fill_idx,
   output logic          i_fill_we,
   output logic          d_fill_we,
   output logic          i_fill_done,
   output logic          d_fill_done,
   output logic          d_wr_done,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FILL  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // A block spans 2*WORDS bytes; the mask clears the in-block byte offset.
   localparam logic [15:0] BLK_MASK = ~(16'(2 * WORDS) - 16'd1);
   localparam logic [IW:0]   ISS_END  = (IW + 1)'(WORDS);
   localparam logic [IW-1:0] RCV_LAST = IW'(WORDS - 1);
   localparam logic [IW:0]   ISS_MIN  = (IW + 1)'((MEM_LAT < WORDS) ? MEM_LAT : WORDS);

   state_t          r_state;
   state_t          w_next;
   logic [15:0]     r_addr;     // store address, or block base during a fill
   logic [15:0]     r_wdata;
   logic            r_owner_d;  // 1: fill belongs to D-cache, 0: I-cache
   logic [IW:0]     r_iss;      // requests issued so far (stops at WORDS)
   logic [IW-1:0]   r_rcv;      // words received so far
   logic            w_issue;

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= 16'h0000;
         r_wdata   <= 16'h0000;
         r_owner_d <= 1'b0;
         r_iss     <= '0;
         r_rcv     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               // Counters are cleared here so every fill starts from word 0.
               r_iss <= '0;
               r_rcv <= '0;
               if (d_wr_req) begin
                  r_addr  <= d_wr_addr;
                  r_wdata <= d_wr_data;
               end else if (d_miss) begin
                  r_addr    <= d_miss_addr & BLK_MASK;
                  r_owner_d <= 1'b1;
               end else if (i_miss) begin
                  r_addr    <= i_miss_addr & BLK_MASK;
                  r_owner_d <= 1'b0;
               end
            end
            S_FILL: begin
               if (w_issue) begin
                  r_iss <= r_iss + 1'b1;
               end
               if (mem_data_valid) begin
                  r_rcv <= r_rcv + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_issue     = 1'b0;
      mem_addr    = 16'h0000;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_data_in = 16'h0000;
      fill_data   = 16'h0000;
      fill_idx    = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_done   = 1'b0;
      busy        = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            // Grant only; the granted access reaches memory next cycle.
            if (d_wr_req) begin
               w_next = S_WRITE;
            end else if (d_miss || i_miss) begin
               w_next = S_FILL;
            end
         end

         S_WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = r_addr;
            mem_data_in = r_wdata;
            d_wr_done   = 1'b1;
            w_next      = S_IDLE;
         end

         S_FILL: begin
            // Requests stream out back-to-back while returns overlap them.
            w_issue = (r_iss < ISS_END);
            if (w_issue) begin
               mem_enable = 1'b1;
               mem_addr   = r_addr | 16'({r_iss[IW-1:0], 1'b0});
            end
            // Returns arrive in issue order, so the receive count is the word index.
            if (mem_data_valid) begin
               fill_data = mem_data_out;
               fill_idx  = r_rcv;
               d_fill_we = r_owner_d;
               i_fill_we = ~r_owner_d;
               if (r_rcv == RCV_LAST) begin
                  w_next = S_DONE;
               end
            end
         end

         S_DONE: begin
            d_fill_done = r_owner_d;
            i_fill_done = ~r_owner_d;
            w_next      = S_IDLE;
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Memory cannot return a word of this fill before MEM_LAT of its requests went out.
   ap_data_after_issue: assert property (@(posedge clk) disable iff (rst)
      (r_state == S_FILL && mem_data_valid) |-> (r_iss >= ISS_MIN));

endmodule
